// File: rtl/pad_ring_pkg.sv
// pad_ring_pkg: shared config field layout, per-side defaults and sequencer states
package pad_ring_pkg;
  localparam int CFG_W = 4;
  localparam int CFG_INP_EN = 0;
  localparam int CFG_OUT_EN = 1;
  localparam int CFG_ANALOG_EN = 2;
  localparam int CFG_PULL_EN = 3;
  localparam logic [CFG_W-1:0] CFG_EAST = CFG_W'(1) << CFG_INP_EN;
  localparam logic [CFG_W-1:0] CFG_SOUTH = CFG_W'(1) << CFG_OUT_EN;
  localparam logic [CFG_W-1:0] CFG_WEST = CFG_W'(1) << CFG_ANALOG_EN;
  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_SHIFT,
    ST_LOAD,
    ST_INP_WAIT,
    ST_READY
  } state_t;
endpackage

// File: rtl/pad_ring_cfg_sequencer_if.sv
// pad_ring_cfg_sequencer_if: core-side config write / apply handshake
interface pad_ring_cfg_sequencer_if #(parameter int NUM_PADS = 24) ();
  import pad_ring_pkg::*;
  logic cfg_wr_valid;
  logic cfg_wr_ready;
  logic [$clog2(NUM_PADS)-1:0] cfg_wr_idx;
  logic [CFG_W-1:0] cfg_wr_data;
  logic cfg_err;
  logic apply_req;
  logic busy;
  modport master (
    output cfg_wr_valid, cfg_wr_idx, cfg_wr_data, apply_req,
    input cfg_wr_ready, cfg_err, busy
  );
  modport slave (
    input cfg_wr_valid, cfg_wr_idx, cfg_wr_data, apply_req,
    output cfg_wr_ready, cfg_err, busy
  );
endinterface

// File: rtl/pad_cfg_shifter.sv
// pad_cfg_shifter: two-phase MSB-first serialiser of a parallel config snapshot
module pad_cfg_shifter #(
  parameter int TOT = 96
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [TOT-1:0] i_snap,
  output logic           o_ser_clk,
  output logic           o_ser_data,
  output logic           o_done
);
  localparam int CW = $clog2(TOT + 1);
  logic [TOT-1:0] r_snap;
  logic [CW-1:0] r_cnt;
  logic r_phase;
  logic r_active;
  assign o_done = r_active & r_phase & (r_cnt == CW'(TOT - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
      r_cnt <= '0;
      r_phase <= 1'b0;
      r_active <= 1'b0;
      o_ser_clk <= 1'b0;
      o_ser_data <= 1'b0;
    end else if (i_start) begin
      r_snap <= i_snap;
      r_cnt <= '0;
      r_phase <= 1'b0;
      r_active <= 1'b1;
      o_ser_clk <= 1'b0;
      o_ser_data <= 1'b0;
    end else if (r_active) begin
      r_phase <= ~r_phase;
      o_ser_clk <= r_phase;
      if (!r_phase) begin
        o_ser_data <= r_snap[TOT-1];
      end else begin
        r_snap <= r_snap << 1;
        r_cnt <= r_cnt + CW'(1);
        r_active <= r_cnt != CW'(TOT - 1);
      end
    end else begin
      o_ser_clk <= 1'b0;
      o_ser_data <= 1'b0;
    end
  end
endmodule

// File: rtl/pad_ring_cfg_sequencer.sv
// pad_ring_cfg_sequencer: pad power-up staging, config bank and serial chain loader
module pad_ring_cfg_sequencer import pad_ring_pkg::*; #(
  parameter int NUM_PADS = 24,
  parameter int PWR_DLY = 16,
  parameter int INP_DLY = 8,
  parameter logic [CFG_W-1:0] DEFAULT_CFG = CFG_EAST
) (
  input  logic                   clk,
  input  logic                   rst,
  pad_ring_cfg_sequencer_if.slave cfg,
  output logic                   pad_enable_h,
  output logic                   pad_enable_inp_h,
  output logic                   ser_clk,
  output logic                   ser_data,
  output logic                   ser_load
);
  localparam int TOT = NUM_PADS * CFG_W;
  localparam int DMAX = PWR_DLY > INP_DLY ? PWR_DLY : INP_DLY;
  localparam int DW = $clog2(DMAX + 1);
  state_t r_state, w_next;
  logic [DW-1:0] r_cnt;
  logic [CFG_W-1:0] r_bank [NUM_PADS];
  logic [CFG_W-1:0] w_bank [NUM_PADS];
  logic [TOT-1:0] w_flat;
  logic r_pending;
  logic w_accept, w_in_range, w_apply, w_start, w_done;
  logic w_ready, w_load, w_en_h, w_en_inp;
  assign w_accept = cfg.cfg_wr_valid & cfg.cfg_wr_ready;
  assign w_in_range = int'(cfg.cfg_wr_idx) < NUM_PADS;
  assign w_apply = cfg.apply_req | r_pending;
  assign w_start = (w_next == ST_SHIFT) && (r_state != ST_SHIFT);
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_PWR_WAIT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PWR_WAIT: w_next = r_cnt == DW'(PWR_DLY - 1) ? ST_SHIFT : ST_PWR_WAIT;
      ST_SHIFT:    w_next = w_done ? ST_LOAD : ST_SHIFT;
      ST_LOAD:     w_next = !pad_enable_inp_h ? ST_INP_WAIT : w_apply ? ST_SHIFT : ST_READY;
      ST_INP_WAIT: w_next = r_cnt == DW'(INP_DLY) ? (w_apply ? ST_SHIFT : ST_READY) : ST_INP_WAIT;
      ST_READY:    w_next = w_apply ? ST_SHIFT : ST_READY;
      default:     w_next = ST_PWR_WAIT;
    endcase
  end
  always_comb begin
    w_ready = w_next == ST_READY;
    w_load = r_state == ST_LOAD;
    w_en_h = pad_enable_h | (r_state == ST_PWR_WAIT && w_next == ST_SHIFT);
    w_en_inp = pad_enable_inp_h | (r_state == ST_INP_WAIT && w_next != ST_INP_WAIT);
  end
  always_comb begin
    w_bank = r_bank;
    w_flat = '0;
    if (w_accept && w_in_range) w_bank[cfg.cfg_wr_idx] = cfg.cfg_wr_data;
    for (int p = 0; p < NUM_PADS; p++) w_flat[p*CFG_W +: CFG_W] = w_bank[p];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_pending <= 1'b0;
      pad_enable_h <= 1'b0;
      pad_enable_inp_h <= 1'b0;
      ser_load <= 1'b0;
      cfg.busy <= 1'b1;
      cfg.cfg_wr_ready <= 1'b0;
      cfg.cfg_err <= 1'b0;
      for (int p = 0; p < NUM_PADS; p++) r_bank[p] <= DEFAULT_CFG;
    end else begin
      r_cnt <= (w_next == r_state && (r_state == ST_PWR_WAIT || r_state == ST_INP_WAIT)) ? r_cnt + DW'(1) : '0;
      if (w_start && r_state != ST_PWR_WAIT) r_pending <= 1'b0;
      else if (cfg.apply_req && r_state != ST_READY) r_pending <= 1'b1;
      pad_enable_h <= w_en_h;
      pad_enable_inp_h <= w_en_inp;
      ser_load <= w_load;
      cfg.busy <= ~w_ready;
      cfg.cfg_wr_ready <= w_ready;
      if (w_accept && !w_in_range) cfg.cfg_err <= 1'b1;
      r_bank <= w_bank;
    end
  end
  pad_cfg_shifter #(.TOT(TOT)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_snap     (w_flat),
    .o_ser_clk  (ser_clk),
    .o_ser_data (ser_data),
    .o_done     (w_done)
  );
endmodule

// File: tb/tb_pad_ring_cfg_sequencer.sv
// tb_pad_ring_cfg_sequencer: randomized self-checking bench against a pad-bank reference model
module tb_pad_ring_cfg_sequencer;
  localparam int NP = 24;
  localparam int CW = 4;
  localparam int PWR = 16;
  localparam int INP = 8;
  localparam int TOT = NP * CW;
  localparam int T_EN = PWR;
  localparam int T_LOAD = PWR + 2 * TOT + 1;
  localparam int T_INP = T_LOAD + INP + 1;
  localparam int T_REAPPLY = 2 * TOT + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pad_enable_h, pad_enable_inp_h, ser_clk, ser_data, ser_load;
  pad_ring_cfg_sequencer_if #(.NUM_PADS(NP)) cfg ();
  pad_ring_cfg_sequencer #(
    .NUM_PADS(NP), .PWR_DLY(PWR), .INP_DLY(INP), .DEFAULT_CFG(4'b0001)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg              (cfg),
    .pad_enable_h     (pad_enable_h),
    .pad_enable_inp_h (pad_enable_inp_h),
    .ser_clk          (ser_clk),
    .ser_data         (ser_data),
    .ser_load         (ser_load)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0;
  int load_cyc = 0;
  logic prev_clk = 1'b0;
  logic bits [$];
  logic [CW-1:0] m_bank [NP];
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  always @(posedge clk) begin
    #1;
    prev_clk <= ser_clk;
    if (ser_clk === 1'b1 && prev_clk === 1'b0) bits.push_back(ser_data);
    if (ser_load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_cyc <= cyc;
    end
  end
  function automatic int stream_errs(int base);
    int e = 0;
    int k = base;
    for (int p = NP - 1; p >= 0; p--)
      for (int b = CW - 1; b >= 0; b--) begin
        if (bits[k] !== m_bank[p][b]) e++;
        k++;
      end
    return e;
  endfunction
  task automatic release_reset();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) m_bank[p] = 4'b0001;
  endtask
  task automatic write_cfg(input int idx, input logic [CW-1:0] data);
    cfg.cfg_wr_valid = 1'b1;
    cfg.cfg_wr_idx = 5'(idx);
    cfg.cfg_wr_data = data;
    @(negedge clk);
    cfg.cfg_wr_valid = 1'b0;
  endtask
  task automatic pulse_apply(input bit wr, input int idx, input logic [CW-1:0] data);
    cfg.cfg_wr_valid = wr;
    cfg.cfg_wr_idx = 5'(idx);
    cfg.cfg_wr_data = data;
    cfg.apply_req = 1'b1;
    @(negedge clk);
    cfg.cfg_wr_valid = 1'b0;
    cfg.apply_req = 1'b0;
  endtask
  task automatic wait_idle(input int budget, output bit to);
    for (int i = 0; i < budget && cfg.busy !== 1'b0; i++) @(negedge clk);
    to = cfg.busy !== 1'b0;
  endtask
  task automatic test_reset();
    logic [7:0] got;
    string names [8] = '{"cfg_err", "cfg_wr_ready", "busy", "ser_load", "ser_data", "ser_clk", "pad_enable_inp_h", "pad_enable_h"};
    logic [7:0] exp_v = 8'b0000_0100;
    rst = 1'b1;
    @(negedge clk);
    got = {pad_enable_h, pad_enable_inp_h, ser_clk, ser_data, ser_load, cfg.busy, cfg.cfg_wr_ready, cfg.cfg_err};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_%s got %b exp %b", names[i], got[i], exp_v[i]);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_bringup();
    int base = bits.size();
    int lb = load_cnt;
    int t_en = -1;
    int t_inp = -1;
    int t_busy = -1;
    for (int i = 0; i < 400 && t_busy < 0; i++) begin
      @(negedge clk);
      if (pad_enable_h === 1'b1 && t_en < 0) t_en = cyc;
      if (pad_enable_inp_h === 1'b1 && t_inp < 0) t_inp = cyc;
      if (cfg.busy === 1'b0) t_busy = cyc;
    end
    checks++;
    if (t_en != T_EN) begin errors++; $display("FAIL bringup_enable_h_cycle got %0d exp %0d", t_en, T_EN); end
    checks++;
    if (load_cnt - lb != 1) begin errors++; $display("FAIL bringup_load_count got %0d exp 1", load_cnt - lb); end
    checks++;
    if (load_cyc != T_LOAD) begin errors++; $display("FAIL bringup_load_cycle got %0d exp %0d", load_cyc, T_LOAD); end
    checks++;
    if (t_inp != T_INP) begin errors++; $display("FAIL bringup_enable_inp_cycle got %0d exp %0d", t_inp, T_INP); end
    checks++;
    if (t_busy != T_INP) begin errors++; $display("FAIL bringup_busy_fall got %0d exp %0d", t_busy, T_INP); end
    checks++;
    if (bits.size() - base != TOT) begin errors++; $display("FAIL bringup_clk_rises got %0d exp %0d", bits.size() - base, TOT); end
    checks++;
    if (bits.size() - base < TOT || stream_errs(base) != 0) begin
      errors++;
      $display("FAIL bringup_stream bad_bits %0d exp 0", bits.size() - base < TOT ? -1 : stream_errs(base));
    end
    checks++;
    if (cfg.cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL bringup_ready got %b exp 1", cfg.cfg_wr_ready); end
  endtask
  task automatic test_write_apply();
    for (int r = 0; r < 3; r++) begin
      int n = r == 0 ? 1 : int'($urandom_range(1, 4));
      int base, c0;
      bit drop = 1'b0;
      bit to;
      for (int w = 0; w < n; w++) begin
        int idx = r == 0 ? 5 : int'($urandom_range(0, NP - 1));
        logic [CW-1:0] d = r == 0 ? 4'b0110 : CW'($urandom);
        checks++;
        if (cfg.cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready got %b exp 1", cfg.cfg_wr_ready); end
        write_cfg(idx, d);
        m_bank[idx] = d;
      end
      base = bits.size();
      c0 = cyc;
      pulse_apply(1'b0, 0, '0);
      for (int i = 0; i < 400 && cfg.busy !== 1'b0; i++) begin
        if (pad_enable_h !== 1'b1 || pad_enable_inp_h !== 1'b1) drop = 1'b1;
        @(negedge clk);
      end
      to = cfg.busy !== 1'b0;
      checks++;
      if (to || drop) begin errors++; $display("FAIL apply_enables timeout %0d drop %0d exp 0 0", to, drop); end
      checks++;
      if (load_cyc - c0 != T_REAPPLY) begin errors++; $display("FAIL apply_latency got %0d exp %0d", load_cyc - c0, T_REAPPLY); end
      checks++;
      if (bits.size() - base != TOT || stream_errs(base) != 0) begin
        errors++;
        $display("FAIL apply_stream round %0d bits %0d exp %0d", r, bits.size() - base, TOT);
      end
    end
  endtask
  task automatic test_pending();
    int base = bits.size();
    int lb = load_cnt;
    int a = $urandom_range(10, 170);
    int b = $urandom_range(10, 170);
    int c = $urandom_range(10, 170);
    bit rdy_bad = 1'b0;
    bit to;
    pulse_apply(1'b0, 0, '0);
    for (int i = 0; i < 700 && cfg.busy !== 1'b0; i++) begin
      cfg.apply_req = (i == a || i == b || i == c);
      if (load_cnt - lb < 2 && cfg.cfg_wr_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
    end
    cfg.apply_req = 1'b0;
    to = cfg.busy !== 1'b0;
    repeat (250) @(negedge clk);
    checks++;
    if (to) begin errors++; $display("FAIL pending_timeout got busy %b exp 0", cfg.busy); end
    checks++;
    if (load_cnt - lb != 2) begin errors++; $display("FAIL pending_loads got %0d exp 2", load_cnt - lb); end
    checks++;
    if (rdy_bad) begin errors++; $display("FAIL pending_ready_early got 1 exp 0"); end
    checks++;
    if (bits.size() - base != 2 * TOT || stream_errs(base) != 0 || stream_errs(base + TOT) != 0) begin
      errors++;
      $display("FAIL pending_stream bits %0d exp %0d", bits.size() - base, 2 * TOT);
    end
  endtask
  task automatic test_oob();
    int base;
    bit to;
    for (int w = 0; w < 2; w++) begin
      int idx = w == 0 ? NP : int'($urandom_range(NP, 31));
      checks++;
      if (cfg.cfg_wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready got %b exp 1", cfg.cfg_wr_ready); end
      write_cfg(idx, CW'($urandom));
      checks++;
      if (cfg.cfg_err !== 1'b1) begin errors++; $display("FAIL oob_err idx %0d got %b exp 1", idx, cfg.cfg_err); end
    end
    base = bits.size();
    pulse_apply(1'b0, 0, '0);
    wait_idle(400, to);
    checks++;
    if (to || cfg.cfg_err !== 1'b1) begin errors++; $display("FAIL oob_err_sticky got %b timeout %0d exp 1 0", cfg.cfg_err, to); end
    checks++;
    if (bits.size() - base != TOT || stream_errs(base) != 0) begin
      errors++;
      $display("FAIL oob_stream bits %0d exp %0d", bits.size() - base, TOT);
    end
  endtask
  task automatic test_same_cycle();
    int base = bits.size();
    logic [CW-1:0] g;
    bit to;
    pulse_apply(1'b1, 0, 4'b1000);
    m_bank[0] = 4'b1000;
    wait_idle(400, to);
    g = 'x;
    if (bits.size() - base == TOT) g = {bits[base+TOT-4], bits[base+TOT-3], bits[base+TOT-2], bits[base+TOT-1]};
    checks++;
    if (to || g !== 4'b1000) begin errors++; $display("FAIL same_cycle_pad0 got %b exp 1000", g); end
    checks++;
    if (bits.size() - base != TOT || stream_errs(base) != 0) begin
      errors++;
      $display("FAIL same_cycle_stream bits %0d exp %0d", bits.size() - base, TOT);
    end
  endtask
  task automatic test_reset_mid();
    int base = bits.size();
    write_cfg(7, 4'b1111);
    pulse_apply(1'b0, 0, '0);
    for (int i = 0; i < 300 && bits.size() - base < 40; i++) @(negedge clk);
    checks++;
    if (bits.size() - base != 40) begin errors++; $display("FAIL midshift_bits got %0d exp 40", bits.size() - base); end
    test_reset();
    release_reset();
    test_bringup();
  endtask
  initial begin
    cfg.cfg_wr_valid = 1'b0;
    cfg.cfg_wr_idx = '0;
    cfg.cfg_wr_data = '0;
    cfg.apply_req = 1'b0;
    test_reset();
    release_reset();
    test_bringup();
    test_write_apply();
    test_pending();
    test_oob();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
